multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Parametrised control sequencer for the multicycle MIPS core. It replaces the single fetch/execute toggle with an explicit phase FSM: FETCH, EXEC, MEM, WB. Memory accesses use a req/ready handshake, so memories with arbitrary latency work without a divided clock. The block owns the PC, the instruction register, the load-data register, the retired-instruction counter and a memory-timeout watchdog. It sits between the decode/execute datapath and the memory master.

## Interface
Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 0, PC value after reset
- TIMEOUT, 15, max consecutive wait cycles per memory access before fault (≥1)
- CNT_W, 32, width of instret counter

Ports:
- clk  in  1  single core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  permit starting a new instruction
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  write strobe, valid with mem_req
- mem_is_fetch  out  1  1 = address from pc[XLEN-1:2], 0 = address from ALU result
- mem_ready  in  1  access complete this cycle; rdata valid
- mem_rdata  in  XLEN  memory read data
- dec_load  in  1  decoded instruction is a load
- dec_store  in  1  decoded instruction is a store
- dec_gp_we  in  1  decoded instruction writes the GPR file
- next_pc  in  XLEN  PC successor from decode
- pc  out  XLEN  current PC
- instr  out  XLEN  instruction register
- load_data  out  XLEN  captured load data
- gpr_we  out  1  GPR write enable
- phase  out  3  current state encoding
- fault  out  1  sticky watchdog fault
- instret  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, EXEC, MEM, WB, FAULT.
- Outputs are Moore, decoded from the state register only.
- IDLE:
  - mem_req=0.
  - run=1 → FETCH; otherwise stay.
- FETCH:
  - mem_req=1, mem_is_fetch=1, mem_we=0.
  - On mem_ready: instr ← mem_rdata, → EXEC.
- EXEC:
  - No request; gives the datapath one cycle to settle.
  - dec_load|dec_store → MEM; otherwise → WB.
- MEM:
  - mem_req=1, mem_is_fetch=0, mem_we=dec_store.
  - On mem_ready: if dec_load, load_data ← mem_rdata. Then → WB.
- WB:
  - gpr_we=dec_gp_we; stores and pure branches write nothing.
  - pc ← next_pc; instret ← instret+1, wrapping modulo 2^CNT_W.
  - run=1 → FETCH; run=0 → IDLE.
- dec_load and dec_store both high: treated as a store. No capture into load_data.
- Watchdog:
  - Counter clears on entry to FETCH or MEM.
  - It increments each cycle with mem_req=1 and mem_ready=0.
  - When the counter reaches TIMEOUT with ready still low → FAULT.
- FAULT:
  - mem_req=0, gpr_we=0, fault=1.
  - pc and instr are frozen for debug.
  - Only rst exits.
- mem_ready while mem_req=0 is ignored.
- run is sampled only in IDLE and WB. Dropping run mid-instruction never aborts the instruction.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, instr=0, load_data=0, instret=0.
  - fault=0, mem_req=0, mem_we=0, mem_is_fetch=0, gpr_we=0.
- rst asserted in any state, including FAULT or mid-handshake, wins on that edge.
  - mem_req drops the following cycle.
  - An in-flight access is abandoned with no register update.
- Handshake: the transfer completes on a rising edge where mem_req=1 and mem_ready=1. It is single-cycle acceptance with no pipelining of requests.
- Instruction cost with mem_ready tied high:
  - ALU/branch: 3 cycles (FETCH, EXEC, WB).
  - Load or store: 4 cycles.
  - Each wait cycle adds 1.
- An access may wait TIMEOUT-1 cycles and still complete. Waiting TIMEOUT cycles faults on that edge.
- gpr_we is high for exactly one cycle per retiring instruction. The PC update and gpr_we occur on the same edge.

## Structure
- Shared package cpu_pkg holds:
  - typedef enum logic [2:0] seq_state_t: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, FAULT=7.
  - Default constants for RESET_PC and TIMEOUT.
- Sub-module mem_watchdog: parameter TIMEOUT; ports clk, rst, clear, waiting, expired.
- FSM, PC, instr, load_data and instret stay in the top.

## Test plan
- Zero-wait ALU instruction: reset, run=1, ready=1, dec_* = 0/0/1, next_pc=4 → phases 1,2,4. gpr_we pulses on cycle 3. pc=4, instret=1.
- Load with 2 wait cycles: dec_load=1, ready low for 2 cycles in MEM, rdata=0xDEADBEEF → load_data=0xDEADBEEF. Retires 6 cycles after leaving IDLE.
- Store: dec_store=1, dec_gp_we=0 → mem_we=1 and mem_is_fetch=0 only in MEM. gpr_we stays 0 in WB.
- Watchdog: TIMEOUT=3, ready never rises in FETCH → fault=1 after 3 wait cycles. mem_req=0, pc unchanged. A later ready=1 has no effect until rst.
- Run gating and reset mid-access: run=0 during EXEC → instruction completes, FSM parks in IDLE. Assert rst during a MEM wait → all outputs at reset values next cycle.
- instret wrap: CNT_W=4, retire 16 instructions → instret=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and defaults for the multicycle MIPS core control path.
//   seq_state_t      : sequencer phase encoding, visible on the phase port
//   DEFAULT_RESET_PC : PC loaded on reset
//   DEFAULT_TIMEOUT  : wait cycles allowed per memory access before a fault
// -----------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      WB    = 3'd4,
      FAULT = 3'd7
   } seq_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned DEFAULT_TIMEOUT  = 32'd15;

endpackage

// File: rtl/mem_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog
// Counts consecutive wait cycles of one memory access and flags expiry.
//   clk     in  : core clock
//   rst     in  : synchronous active-high reset
//   clear   in  : no access in progress; counter held at zero
//   waiting in  : request outstanding and memory not ready this cycle
//   expired out : this cycle is wait number TIMEOUT; the access must fault
// -----------------------------------------------------------------------------
module mem_watchdog #(
   parameter int unsigned TIMEOUT = 32'd15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic waiting,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 32'd1);

   logic [CW-1:0] r_cnt;

   // Counter holds the number of wait cycles already spent by the current access.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (waiting && (r_cnt != CW'(TIMEOUT))) begin
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // TIMEOUT-1 waits already elapsed and still not ready: this edge faults.
   assign expired = waiting && (r_cnt == CW'(TIMEOUT - 32'd1));

endmodule

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
// Phase FSM (IDLE/FETCH/EXEC/MEM/WB/FAULT) for the multicycle MIPS core with a
// req/ready memory handshake. Owns PC, instruction register, load-data
// register, retired-instruction counter and the memory timeout watchdog.
//   clk, rst              : core clock, synchronous active-high reset
//   run                   : permit starting a new instruction (IDLE/WB only)
//   mem_req/mem_we        : memory request (held until ready) and write strobe
//   mem_is_fetch          : 1 = instruction fetch from pc, 0 = data access
//   mem_ready/mem_rdata   : access completion and read data
//   dec_load/store/gp_we  : decoded instruction class from the datapath
//   next_pc               : PC successor from decode
//   pc/instr/load_data    : architectural registers held here
//   gpr_we                : GPR write enable, one cycle per retired instruction
//   phase/fault/instret   : state encoding, sticky fault, retired count
// -----------------------------------------------------------------------------
module multicycle_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned      XLEN     = 32'd32,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
   parameter int unsigned      TIMEOUT  = DEFAULT_TIMEOUT,
   parameter int unsigned      CNT_W    = 32'd32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_is_fetch,
   input  logic             mem_ready,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic             dec_load,
   input  logic             dec_store,
   input  logic             dec_gp_we,
   input  logic [XLEN-1:0]  next_pc,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  instr,
   output logic [XLEN-1:0]  load_data,
   output logic             gpr_we,
   output logic [2:0]       phase,
   output logic             fault,
   output logic [CNT_W-1:0] instret
);

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_instr;
   logic [XLEN-1:0]  r_load_data;
   logic [CNT_W-1:0] r_instret;
   logic             w_access;
   logic             w_waiting;
   logic             w_expired;

   // Ready is only meaningful while a request is outstanding.
   assign w_access  = (r_state == FETCH) || (r_state == MEM);
   assign w_waiting = w_access && !mem_ready;

   mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (!w_access),
      .waiting (w_waiting),
      .expired (w_expired)
   );

   // Phase state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-phase logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (run) w_state_nxt = FETCH;
            else     w_state_nxt = IDLE;
         end
         FETCH: begin
            if (mem_ready)      w_state_nxt = EXEC;
            else if (w_expired) w_state_nxt = FAULT;
            else                w_state_nxt = FETCH;
         end
         EXEC: begin
            if (dec_load || dec_store) w_state_nxt = MEM;
            else                       w_state_nxt = WB;
         end
         MEM: begin
            if (mem_ready)      w_state_nxt = WB;
            else if (w_expired) w_state_nxt = FAULT;
            else                w_state_nxt = MEM;
         end
         WB: begin
            if (run) w_state_nxt = FETCH;
            else     w_state_nxt = IDLE;
         end
         FAULT:   w_state_nxt = FAULT;
         // Unreachable encodings are treated as a fault so they stay visible.
         default: w_state_nxt = FAULT;
      endcase
   end

   // Instruction register: captured on fetch completion, frozen otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr <= '0;
      end else if ((r_state == FETCH) && mem_ready) begin
         r_instr <= mem_rdata;
      end else begin
         r_instr <= r_instr;
      end
   end

   // Load data: a load that is also flagged as a store behaves as a store.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_load_data <= '0;
      end else if ((r_state == MEM) && mem_ready && dec_load && !dec_store) begin
         r_load_data <= mem_rdata;
      end else begin
         r_load_data <= r_load_data;
      end
   end

   // PC and retired count advance together on the WB edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_instret <= '0;
      end else if (r_state == WB) begin
         r_pc      <= next_pc;
         r_instret <= r_instret + CNT_W'(1);
      end else begin
         r_pc      <= r_pc;
         r_instret <= r_instret;
      end
   end

   // Moore output decode from the phase register.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_fetch = 1'b0;
      gpr_we       = 1'b0;
      fault        = 1'b0;
      case (r_state)
         FETCH: begin
            mem_req      = 1'b1;
            mem_is_fetch = 1'b1;
         end
         MEM: begin
            mem_req = 1'b1;
            mem_we  = dec_store;
         end
         WB:      gpr_we = dec_gp_we;
         FAULT:   fault  = 1'b1;
         default: begin
            mem_req = 1'b0;
         end
      endcase
   end

   assign phase     = r_state;
   assign pc        = r_pc;
   assign instr     = r_instr;
   assign load_data = r_load_data;
   assign instret   = r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed bench for multicycle_sequencer with TIMEOUT=3 and CNT_W=4.
// Inputs change 1 ns after the rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

   logic        clk;
   logic        rst;
   logic        run;
   logic        mem_req;
   logic        mem_we;
   logic        mem_is_fetch;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        dec_load;
   logic        dec_store;
   logic        dec_gp_we;
   logic [31:0] next_pc;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] load_data;
   logic        gpr_we;
   logic [2:0]  phase;
   logic        fault;
   logic [3:0]  instret;

   int n_checks = 0;
   int n_errors = 0;
   int n_gpr_we = 0;

   multicycle_sequencer #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (3),
      .CNT_W    (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_is_fetch (mem_is_fetch),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .dec_load     (dec_load),
      .dec_store    (dec_store),
      .dec_gp_we    (dec_gp_we),
      .next_pc      (next_pc),
      .pc           (pc),
      .instr        (instr),
      .load_data    (load_data),
      .gpr_we       (gpr_we),
      .phase        (phase),
      .fault        (fault),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      run       = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      dec_load  = 1'b0;
      dec_store = 1'b0;
      dec_gp_we = 1'b0;
      next_pc   = 32'h0;
      do_reset();

      // Reset state
      check("rst_phase",   64'(phase),        64'd0);
      check("rst_pc",      64'(pc),           64'd0);
      check("rst_instr",   64'(instr),        64'd0);
      check("rst_ld",      64'(load_data),    64'd0);
      check("rst_instret", 64'(instret),      64'd0);
      check("rst_fault",   64'(fault),        64'd0);
      check("rst_req",     64'(mem_req),      64'd0);
      check("rst_we",      64'(mem_we),       64'd0);
      check("rst_isf",     64'(mem_is_fetch), 64'd0);
      check("rst_gprwe",   64'(gpr_we),       64'd0);

      // Zero-wait ALU instruction; run dropped during the instruction
      run = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
      dec_load = 1'b0; dec_store = 1'b0; dec_gp_we = 1'b1; next_pc = 32'h4;
      tick();
      check("alu_ph1",   64'(phase),        64'd1);
      check("alu_req",   64'(mem_req),      64'd1);
      check("alu_isf",   64'(mem_is_fetch), 64'd1);
      check("alu_gw1",   64'(gpr_we),       64'd0);
      run = 1'b0;
      tick();
      check("alu_ph2",   64'(phase),        64'd2);
      check("alu_instr", 64'(instr),        64'h1111_1111);
      check("alu_req2",  64'(mem_req),      64'd0);
      tick();
      check("alu_ph4",   64'(phase),        64'd4);
      check("alu_gw3",   64'(gpr_we),       64'd1);
      check("alu_pc_wb", 64'(pc),           64'd0);
      tick();
      check("alu_park",  64'(phase),        64'd0);
      check("alu_pc",    64'(pc),           64'h4);
      check("alu_ret",   64'(instret),      64'd1);
      check("alu_gw4",   64'(gpr_we),       64'd0);

      // Load with two wait cycles in MEM
      run = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h2222_2222;
      dec_load = 1'b1; dec_store = 1'b0; dec_gp_we = 1'b1; next_pc = 32'h8;
      tick();
      check("ld_ph1", 64'(phase), 64'd1);
      run = 1'b0;
      tick();
      check("ld_ph2",   64'(phase), 64'd2);
      check("ld_instr", 64'(instr), 64'h2222_2222);
      mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      tick();
      check("ld_ph3",  64'(phase),        64'd3);
      check("ld_req",  64'(mem_req),      64'd1);
      check("ld_isf",  64'(mem_is_fetch), 64'd0);
      check("ld_we",   64'(mem_we),       64'd0);
      tick();
      check("ld_w1",   64'(phase), 64'd3);
      tick();
      check("ld_w2",   64'(phase), 64'd3);
      check("ld_flt",  64'(fault), 64'd0);
      mem_ready = 1'b1;
      tick();
      check("ld_wb",   64'(phase),     64'd4);
      check("ld_data", 64'(load_data), 64'hDEAD_BEEF);
      check("ld_gw",   64'(gpr_we),    64'd1);
      tick();
      check("ld_pc",   64'(pc),      64'h8);
      check("ld_ret",  64'(instret), 64'd2);

      // Store: write strobe only in MEM, no GPR write
      run = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h3333_3333;
      dec_load = 1'b0; dec_store = 1'b1; dec_gp_we = 1'b0; next_pc = 32'hC;
      tick();
      check("st_we_f",  64'(mem_we), 64'd0);
      run = 1'b0;
      tick();
      check("st_we_e",  64'(mem_we), 64'd0);
      tick();
      check("st_ph3",   64'(phase),        64'd3);
      check("st_we_m",  64'(mem_we),       64'd1);
      check("st_isf_m", 64'(mem_is_fetch), 64'd0);
      tick();
      check("st_ph4",   64'(phase),  64'd4);
      check("st_gw",    64'(gpr_we), 64'd0);
      check("st_we_wb", 64'(mem_we), 64'd0);
      tick();
      check("st_pc",    64'(pc),      64'hC);
      check("st_ret",   64'(instret), 64'd3);

      // Load and store together: behaves as a store, load_data untouched
      run = 1'b1; mem_rdata = 32'h4444_4444;
      dec_load = 1'b1; dec_store = 1'b1; dec_gp_we = 1'b0; next_pc = 32'h10;
      tick();
      run = 1'b0;
      tick();
      tick();
      check("ls_we",  64'(mem_we), 64'd1);
      tick();
      check("ls_ld",  64'(load_data), 64'hDEAD_BEEF);
      tick();
      check("ls_ret", 64'(instret), 64'd4);

      // Reset during a MEM wait abandons the access
      run = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5050_5050;
      dec_load = 1'b1; dec_store = 1'b0; dec_gp_we = 1'b1; next_pc = 32'h14;
      tick();
      run = 1'b0;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      check("rm_ph3", 64'(phase), 64'd3);
      rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      check("rm_phase", 64'(phase),     64'd0);
      check("rm_req",   64'(mem_req),   64'd0);
      check("rm_ld",    64'(load_data), 64'd0);
      check("rm_pc",    64'(pc),        64'd0);
      check("rm_instr", 64'(instr),     64'd0);
      check("rm_ret",   64'(instret),   64'd0);
      rst = 1'b0;

      // Watchdog: fetch never acknowledged
      run = 1'b1; mem_ready = 1'b0; dec_load = 1'b0; dec_gp_we = 1'b1;
      tick();
      tick();
      tick();
      check("wd_w3_ph",  64'(phase), 64'd1);
      check("wd_w3_flt", 64'(fault), 64'd0);
      tick();
      check("wd_ph",  64'(phase),   64'd7);
      check("wd_flt", 64'(fault),   64'd1);
      check("wd_req", 64'(mem_req), 64'd0);
      check("wd_pc",  64'(pc),      64'd0);
      mem_ready = 1'b1; mem_rdata = 32'h6666_6666;
      tick();
      tick();
      check("wd_stay",  64'(phase),  64'd7);
      check("wd_instr", 64'(instr),  64'd0);
      check("wd_gw",    64'(gpr_we), 64'd0);
      do_reset();
      check("wd_clr",   64'(fault),  64'd0);
      check("wd_ph0",   64'(phase),  64'd0);

      // instret wrap: 16 back-to-back ALU instructions at 3 cycles each
      run = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0;
      dec_load = 1'b0; dec_store = 1'b0; dec_gp_we = 1'b1; next_pc = 32'h100;
      n_gpr_we = 0;
      tick();
      for (int i = 0; i < 45; i++) begin
         if (gpr_we) n_gpr_we++;
         tick();
      end
      check("wr_15",  64'(instret), 64'd15);
      for (int i = 0; i < 3; i++) begin
         if (gpr_we) n_gpr_we++;
         tick();
      end
      check("wr_0",   64'(instret),  64'd0);
      check("wr_ph",  64'(phase),    64'd1);
      check("wr_pc",  64'(pc),       64'h100);
      check("wr_gw",  64'(n_gpr_we), 64'd16);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
